// File: rtl/timer_pkg.sv
// Shared constants for the Wishbone timer: register offsets, control/status bit
// positions and a byte-lane merge helper for 32-bit registers.
package timer_pkg;

    localparam int DataWidth = 32;
    localparam int AddrWidth = 32;
    localparam int SelWidth  = DataWidth / 8;

    localparam logic [2:0] RegCtrl     = 3'd0;
    localparam logic [2:0] RegPrescale = 3'd1;
    localparam logic [2:0] RegCount    = 3'd2;
    localparam logic [2:0] RegCompare  = 3'd3;
    localparam logic [2:0] RegStatus   = 3'd4;

    localparam int CtrlEnable     = 0;
    localparam int CtrlAutoReload = 1;
    localparam int CtrlIrqEn      = 2;
    localparam int StatusMatch    = 0;

    // Replace only the bytes whose select bit is set.
    function automatic logic [DataWidth-1:0] apply_sel(
        input logic [DataWidth-1:0] old_val,
        input logic [DataWidth-1:0] wr_val,
        input logic [SelWidth-1:0]  sel
    );
        logic [DataWidth-1:0] res;
        res = old_val;
        for (int i = 0; i < SelWidth; i++) begin
            if (sel[i]) res[i*8 +: 8] = wr_val[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_timer_if.sv
// Pipelined Wishbone slave-slot bundle. A request is valid on any cycle with
// bus_cyc & bus_stb; bus_stall never rises, so every such cycle is accepted, and
// exactly one of bus_ack/bus_err answers it on the following cycle while bus_cyc holds.
interface wb_timer_if;
    import timer_pkg::*;

    logic [DataWidth-1:0] bus_data_m;
    logic [AddrWidth-1:0] bus_addr;
    logic [SelWidth-1:0]  bus_sel;
    logic                 bus_cyc;
    logic                 bus_stb;
    logic                 bus_we;
    logic [DataWidth-1:0] bus_data_s;
    logic                 bus_ack;
    logic                 bus_stall;
    logic                 bus_err;

    modport master (
        output bus_data_m, bus_addr, bus_sel, bus_cyc, bus_stb, bus_we,
        input  bus_data_s, bus_ack, bus_stall, bus_err
    );

    modport slave (
        input  bus_data_m, bus_addr, bus_sel, bus_cyc, bus_stb, bus_we,
        output bus_data_s, bus_ack, bus_stall, bus_err
    );

endinterface

// File: rtl/timer_prescaler.sv
// Prescale counter: counts 0..limit while enabled and pulses tick on the limit
// cycle, giving one tick every limit+1 clocks.
module timer_prescaler #(
    parameter int Width = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable_i,
    input  logic             clear_i,
    input  logic [Width-1:0] limit_i,
    output logic             tick_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    // Tick depends only on flops, so it cannot glitch on bus activity.
    assign tick_o = enable_i && (cnt_q == limit_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/wb_timer.sv
// Wishbone timer peripheral: bus front-end, register file, free-running counter
// with compare/match and a flop-only interrupt output.
module wb_timer
    import timer_pkg::*;
#(
    parameter int PrescaleWidth = 16
) (
    input  logic       clk,
    input  logic       reset,
    wb_timer_if.slave  bus,
    output logic       irq
);

    logic [2:0]               ctrl_q, ctrl_d;
    logic [PrescaleWidth-1:0] prescale_q, prescale_d;
    logic [DataWidth-1:0]     count_q, count_d;
    logic [DataWidth-1:0]     compare_q, compare_d;
    logic                     match_q, match_d;
    logic                     ack_q, ack_d;
    logic                     err_q, err_d;
    logic [DataWidth-1:0]     rdata_q, rdata_d;

    logic [2:0]           offset;
    logic                 req, mapped;
    logic                 wr_ctrl, wr_pre, wr_count, wr_cmp, wr_status;
    logic                 tick, hit;
    logic [DataWidth-1:0] rd_val;
    logic                 unused_addr_bits;

    assign unused_addr_bits = ^{bus.bus_addr[AddrWidth-1:5], bus.bus_addr[1:0]};

    assign offset    = bus.bus_addr[4:2];
    assign req       = bus.bus_cyc & bus.bus_stb;
    assign mapped    = (offset <= RegStatus);
    assign wr_ctrl   = req & bus.bus_we & (offset == RegCtrl);
    assign wr_pre    = req & bus.bus_we & (offset == RegPrescale);
    assign wr_count  = req & bus.bus_we & (offset == RegCount);
    assign wr_cmp    = req & bus.bus_we & (offset == RegCompare);
    assign wr_status = req & bus.bus_we & (offset == RegStatus);

    timer_prescaler #(.Width(PrescaleWidth)) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .enable_i (ctrl_q[CtrlEnable]),
        .clear_i  (wr_pre && (|bus.bus_sel)),
        .limit_i  (prescale_q),
        .tick_o   (tick)
    );

    assign hit = (count_q == compare_q);

    always_comb begin
        rd_val = '0;
        case (offset)
            RegCtrl:     rd_val = DataWidth'(ctrl_q);
            RegPrescale: rd_val = DataWidth'(prescale_q);
            RegCount:    rd_val = count_q;
            RegCompare:  rd_val = compare_q;
            RegStatus:   rd_val = DataWidth'(match_q);
            default:     rd_val = '0;
        endcase
    end

    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        compare_d  = compare_q;
        count_d    = count_q;
        match_d    = match_q;

        if (wr_ctrl && bus.bus_sel[0]) ctrl_d = bus.bus_data_m[2:0];
        if (wr_pre) begin
            for (int i = 0; i < PrescaleWidth; i++) begin
                if (bus.bus_sel[i/8]) prescale_d[i] = bus.bus_data_m[i];
            end
        end
        if (wr_cmp) compare_d = apply_sel(compare_q, bus.bus_data_m, bus.bus_sel);

        // A bus write to COUNT overrides the tick update in the same cycle.
        if (tick) count_d = (hit && ctrl_q[CtrlAutoReload]) ? '0 : count_q + 1'b1;
        if (wr_count) count_d = apply_sel(count_q, bus.bus_data_m, bus.bus_sel);

        // A new match wins over a simultaneous W1C clear.
        if (wr_status && bus.bus_sel[0] && bus.bus_data_m[StatusMatch]) match_d = 1'b0;
        if (tick && hit) match_d = 1'b1;
    end

    always_comb begin
        ack_d   = req & mapped;
        err_d   = req & ~mapped;
        rdata_d = (req && !bus.bus_we && mapped) ? rd_val : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            match_q    <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            match_q    <= match_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    // A response is only presented while the master still holds the cycle.
    assign bus.bus_ack    = ack_q & bus.bus_cyc;
    assign bus.bus_err    = err_q & bus.bus_cyc;
    assign bus.bus_data_s = (ack_q && bus.bus_cyc) ? rdata_q : '0;
    assign bus.bus_stall  = 1'b0;

    assign irq = match_q & ctrl_q[CtrlIrqEn];

endmodule

// File: tb/tb_wb_timer.sv
// Directed bench for wb_timer: register access, prescaled counting, compare/IRQ,
// wrap, unmapped offsets, byte lanes, back-to-back access and async reset.
module tb_wb_timer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic irq;
    int   n_vec = 0;
    int   n_err = 0;

    logic        r_ack, r_err, r_stall;
    logic [31:0] r_data;

    wb_timer_if bus_if ();

    wb_timer #(.PrescaleWidth(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Starts #1 after a rising edge; returns #1 after the acceptance edge with
    // the response captured and the strobe dropped (cyc still high).
    task automatic bus_issue(input logic we, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] sel);
        bus_if.bus_cyc    = 1'b1;
        bus_if.bus_stb    = 1'b1;
        bus_if.bus_we     = we;
        bus_if.bus_addr   = addr;
        bus_if.bus_data_m = data;
        bus_if.bus_sel    = sel;
        @(posedge clk); #1;
        bus_if.bus_stb = 1'b0;
        bus_if.bus_we  = 1'b0;
        r_ack   = bus_if.bus_ack;
        r_err   = bus_if.bus_err;
        r_stall = bus_if.bus_stall;
        r_data  = bus_if.bus_data_s;
    endtask

    task automatic bus_close();
        @(posedge clk); #1;
        bus_if.bus_cyc = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] sel);
        bus_issue(1'b1, addr, data, sel);
        bus_close();
        check({tag, ".ack"}, 32'(r_ack), 32'd1);
        check({tag, ".err"}, 32'(r_err), 32'd0);
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        bus_issue(1'b0, addr, 32'h0, 4'h0);
        bus_close();
        check({tag, ".ack"}, 32'(r_ack), 32'd1);
        check({tag, ".err"}, 32'(r_err), 32'd0);
        check({tag, ".stall"}, 32'(r_stall), 32'd0);
        check({tag, ".data"}, r_data, exp);
    endtask

    task automatic acc_err(input string tag, input logic we, input logic [31:0] addr);
        bus_issue(we, addr, 32'hFFFF_FFFF, 4'hF);
        bus_close();
        check({tag, ".err"}, 32'(r_err), 32'd1);
        check({tag, ".ack"}, 32'(r_ack), 32'd0);
        check({tag, ".data"}, r_data, 32'd0);
    endtask

    logic [31:0] b2b_addr [4];
    logic [31:0] b2b_exp  [4];

    initial begin
        bus_if.bus_cyc    = 1'b0;
        bus_if.bus_stb    = 1'b0;
        bus_if.bus_we     = 1'b0;
        bus_if.bus_addr   = 32'h0;
        bus_if.bus_data_m = 32'h0;
        bus_if.bus_sel    = 4'h0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        check("rst.ack", 32'(bus_if.bus_ack), 32'd0);
        check("rst.err", 32'(bus_if.bus_err), 32'd0);
        check("rst.irq", 32'(irq), 32'd0);
        rd("rst.ctrl",     32'h00, 32'h0);
        rd("rst.prescale", 32'h04, 32'h0);
        rd("rst.count",    32'h08, 32'h0);
        rd("rst.compare",  32'h0C, 32'h0);
        rd("rst.status",   32'h10, 32'h0);

        // Prescale 3: one tick per 4 clocks, match on the 6th tick
        wr("t2.pre", 32'h04, 32'h3, 4'hF);
        wr("t2.cmp", 32'h0C, 32'h5, 4'hF);
        wr("t2.ctrl", 32'h00, 32'h1, 4'hF);
        repeat (20) @(posedge clk);
        #1;
        rd("t2.count5", 32'h08, 32'd5);
        rd("t2.nomatch", 32'h10, 32'd0);
        rd("t2.count6", 32'h08, 32'd6);
        rd("t2.match", 32'h10, 32'd1);
        check("t2.irq_off", 32'(irq), 32'd0);

        // Prescale 0 with auto-reload and irq
        wr("t3.dis", 32'h00, 32'h0, 4'hF);
        wr("t3.cnt", 32'h08, 32'h0, 4'hF);
        wr("t3.pre", 32'h04, 32'h0, 4'hF);
        wr("t3.cmp", 32'h0C, 32'h2, 4'hF);
        wr("t3.w1c", 32'h10, 32'h1, 4'hF);
        rd("t3.st0", 32'h10, 32'd0);
        wr("t3.ctrl", 32'h00, 32'h7, 4'hF);
        rd("t3.seq1", 32'h08, 32'd1);
        rd("t3.seq0", 32'h08, 32'd0);
        rd("t3.seq2", 32'h08, 32'd2);
        check("t3.irq1", 32'(irq), 32'd1);
        bus_issue(1'b1, 32'h10, 32'h1, 4'h1);
        check("t3.clr.ack", 32'(r_ack), 32'd1);
        check("t3.irq_clr", 32'(irq), 32'd0);
        bus_close();
        check("t3.irq_again", 32'(irq), 32'd1);

        // Wrap at 2^32 without a match
        wr("t4.dis", 32'h00, 32'h0, 4'hF);
        wr("t4.cnt", 32'h08, 32'hFFFF_FFFF, 4'hF);
        wr("t4.cmp", 32'h0C, 32'h10, 4'hF);
        wr("t4.w1c", 32'h10, 32'h1, 4'hF);
        wr("t4.pre", 32'h04, 32'h0, 4'hF);
        wr("t4.ctrl", 32'h00, 32'h1, 4'hF);
        rd("t4.wrap", 32'h08, 32'd0);
        rd("t4.nomatch", 32'h10, 32'd0);
        wr("t4.dis2", 32'h00, 32'h0, 4'hF);
        check("t4.irq", 32'(irq), 32'd0);

        // Unmapped offsets and ignored address bits
        wr("t5.pre", 32'h04, 32'hFFFF_00AB, 4'hF);
        acc_err("t5.rd14", 1'b0, 32'h14);
        acc_err("t5.rd1c", 1'b0, 32'h1C);
        acc_err("t5.wr18", 1'b1, 32'h18);
        rd("t5.pre_rb", 32'h04, 32'h0000_00AB);
        rd("t5.cmp_alias", 32'hFFFF_FFEF, 32'h10);
        rd("t5.ctrl_rb", 32'h00, 32'h0);

        // Byte lanes
        wr("t6.cnt0", 32'h08, 32'h0, 4'hF);
        wr("t6.part", 32'h08, 32'h1234_5678, 4'b0101);
        rd("t6.part_rb", 32'h08, 32'h0034_0078);
        wr("t6.sel0", 32'h08, 32'hFFFF_FFFF, 4'b0000);
        rd("t6.sel0_rb", 32'h08, 32'h0034_0078);

        // Four back-to-back reads
        b2b_addr[0] = 32'h00; b2b_exp[0] = 32'h0;
        b2b_addr[1] = 32'h04; b2b_exp[1] = 32'hAB;
        b2b_addr[2] = 32'h08; b2b_exp[2] = 32'h0034_0078;
        b2b_addr[3] = 32'h0C; b2b_exp[3] = 32'h10;
        bus_if.bus_cyc  = 1'b1;
        bus_if.bus_stb  = 1'b1;
        bus_if.bus_we   = 1'b0;
        bus_if.bus_sel  = 4'h0;
        bus_if.bus_addr = b2b_addr[0];
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("b2b%0d.ack", i), 32'(bus_if.bus_ack), 32'd1);
            check($sformatf("b2b%0d.data", i), bus_if.bus_data_s, b2b_exp[i]);
            if (i < 3) bus_if.bus_addr = b2b_addr[i+1];
            else       bus_if.bus_stb  = 1'b0;
        end
        @(posedge clk); #1;
        check("b2b.idle_ack", 32'(bus_if.bus_ack), 32'd0);
        bus_if.bus_cyc = 1'b0;

        // Response dropped when cyc falls in the response cycle
        bus_issue(1'b0, 32'h0C, 32'h0, 4'h0);
        bus_if.bus_cyc = 1'b0;
        #1;
        check("drop.ack", 32'(bus_if.bus_ack), 32'd0);
        check("drop.data", bus_if.bus_data_s, 32'd0);
        @(posedge clk); #1;

        // Async reset during a pending response
        bus_issue(1'b0, 32'h0C, 32'h0, 4'h0);
        check("rstx.pend_ack", 32'(r_ack), 32'd1);
        reset = 1'b1;
        #1;
        check("rstx.ack", 32'(bus_if.bus_ack), 32'd0);
        check("rstx.data", bus_if.bus_data_s, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        bus_if.bus_cyc = 1'b0;
        rd("rstx.cmp", 32'h0C, 32'h0);
        rd("rstx.pre", 32'h04, 32'h0);
        rd("rstx.count", 32'h08, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
